digit_scan: RTL and testbench
=============================

Name: digit_scan

Overview:
- Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
- Holds a shadow copy of N BCD digits and presents one digit at a time on bcd_o to the downstream BCD-to-segment decoder.
- Drives the matching active-low digit enable and sequences all digits continuously.
- Adds anti-ghosting dead time, leading-zero blanking and invalid-code blanking, so the decoder never sees a non-BCD code on a lit digit.

Parameters:
- NUM_DIGITS, 4, number of display digits; legal range 2..8.
- SCAN_DIV, 50000, clock cycles per digit slot; minimum 2.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_n_i  input  1  synchronous reset, active-low.
- en_i  input  1  scan enable; low freezes scanning and darkens the display.
- load_i  input  1  one-cycle strobe; captures digits_i into the shadow register.
- digits_i  input  4*NUM_DIGITS  packed BCD digits; digit k is bits [4k+3:4k]; k=0 is least significant (rightmost).
- blank_lz_i  input  1  high enables leading-zero blanking.
- bcd_o  output  4  BCD code for the current digit, to the segment decoder.
- digit_sel_o  output  NUM_DIGITS  active-low digit enables; bit k drives digit k.
- frame_o  output  1  one-cycle pulse when the scan wraps from the last digit back to digit 0.
- err_o  output  1  sticky flag: a shadowed digit held a code greater than 9.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - shadow = 0, prescaler = 0, index = 0.
  - bcd_o = 0, digit_sel_o = all ones, frame_o = 0, err_o = 0.
  - Reset mid-slot aborts the current slot immediately; the next cycle starts the digit 0 slot with its dead cycle.
- Shadow register:
  - When load_i is high at an edge, the shadow takes digits_i.
  - Every other cycle the shadow holds, so digits_i may change freely without tearing.
- Prescaler:
  - When en_i is high, the prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the terminal count (SCAN_DIV-1), index increments; it wraps from NUM_DIGITS-1 to 0.
  - When en_i is low, the prescaler and index hold.
- Outputs are registered, with one cycle of latency from the prescaler and index state:
  - bcd_o = shadow[index], or 0 if that digit is invalid.
  - digit_sel_o = all ones when en_i is low, when prescaler == 0 (dead cycle), or when the current digit is blanked.
  - Otherwise digit_sel_o = ~(1 << index).
  - Exactly one bit of digit_sel_o is low at any time, or none.
- Digit blanking:
  - A digit is invalid if its code is greater than 9. Invalid digits are blanked and set err_o.
  - err_o clears only on reset.
  - Leading-zero blanking applies only when blank_lz_i is high: digit k (k ≥ 1) is blanked when it and every digit above it are 0.
  - Digit 0 is never blanked for zero, so value 0 displays "0".
- frame_o:
  - Registered high for exactly one cycle, in the cycle after index wraps to 0.
  - It is not asserted while en_i is low.
- Simultaneous events:
  - load_i coincident with the terminal count: both take effect. The new shadow value is presented in the new slot.
  - en_i falling mid-slot: the display darkens on the next cycle.
  - en_i rising: scanning resumes from the held prescaler and index. The resume cycle is not forced dead unless prescaler == 0.
- Timing: one full frame = NUM_DIGITS*SCAN_DIV cycles; each digit is lit for SCAN_DIV-1 cycles per frame.

Decomposition:
- Shared package holds:
  - BCD_MAX = 9.
  - DIGIT_OFF = all-ones select pattern helper.
  - A function returning the one-hot active-low select for an index.
- One natural sub-module, scan_prescaler:
  - Parameterised modulo-SCAN_DIV counter with enable.
  - Outputs a terminal-count strobe and a zero flag.
  - Instantiated once.
- The segment decoder is instantiated beside this block at the display top level, not inside it.

Test Plan:
- Run with NUM_DIGITS=4, SCAN_DIV=4.
- Reset and load: load digits_i=0x1234, en_i=1 → each 4-cycle slot has 1 dead cycle (digit_sel_o=1111), then 3 cycles of:
  - bcd_o=4, digit_sel_o=1110;
  - then bcd_o=3, 1101;
  - then 2, 1011;
  - then 1, 0111.
  - frame_o pulses once every 16 cycles.
- Leading zeros: load 0x0050 with blank_lz_i=1 → digits 3 and 2 stay dark (sel 1111 in their slots); digits 1 and 0 show 5 and 0. With blank_lz_i=0, all four digits light.
- Value zero: load 0x0000 with blank_lz_i=1 → only digit 0 lights, showing bcd_o=0.
- Invalid code: load 0x12A4 → digit 1 slot stays dark with bcd_o=0; err_o rises and stays high until rst_n_i=0.
- Enable and load interaction:
  - Drop en_i mid-slot → digit_sel_o=1111 next cycle and the counters freeze; raising en_i resumes from the same index and count.
  - Assert load_i (0x9876) on a terminal-count cycle → the next slot shows the new digit.
- Mid-scan reset: assert rst_n_i=0 during the digit 2 slot → next cycle all outputs are at reset values; after release, scanning restarts at digit 0 with a dead cycle.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package digit_scan_pkg;

  // Widest display the driver supports; internal per-digit tables use this size.
  localparam int         MAX_DIGITS = 8;
  // Largest legal BCD code.
  localparam logic [3:0] BCD_MAX    = 4'd9;
  // All digit enables inactive (active-low), truncated by the user to its width.
  localparam logic [7:0] DIGIT_OFF  = 8'hFF;

  // One-hot active-low digit select for a digit index.
  function automatic logic [7:0] sel_onehot_n(input logic [2:0] idx);
    sel_onehot_n = ~(8'd1 << idx);
  endfunction

  // True when a 4-bit code is a displayable decimal digit.
  function automatic logic bcd_valid(input logic [3:0] code);
    bcd_valid = (code <= BCD_MAX);
  endfunction

endpackage

// File: rtl/digit_scan_prescaler.sv
// Modulo-SCAN_DIV slot counter with enable; flags slot start and slot end.
module scan_prescaler #(
  parameter int  SCAN_DIV = 50000,
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tc_o,
  output logic zero_o
);

  logic [CNT_W-1:0] count_r;

  // Slot position counter: wraps at SCAN_DIV-1, holds while disabled.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en_i) begin
      if (count_r == CNT_W'(SCAN_DIV - 1)) begin
        count_r <= {CNT_W{1'b0}};
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign tc_o   = (count_r == CNT_W'(SCAN_DIV - 1));
  assign zero_o = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/digit_scan.sv
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
// Presents one shadowed BCD digit at a time with its active-low digit enable,
// inserting a dead cycle at each slot start and blanking leading zeros and
// non-BCD codes so the downstream decoder never lights an invalid code.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    blank_lz_i,
  output logic [3:0]              bcd_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_o,
  output logic                    err_o
);

  logic [4*NUM_DIGITS-1:0] shadow_r;
  logic [2:0]              index_r;
  logic                    tc_s;
  logic                    zero_s;
  logic                    step_s;
  logic [31:0]             shadow_pad_s;
  logic [3:0]              dig_s [MAX_DIGITS];
  logic [7:0]              inv_s;
  logic [7:0]              lz_s;
  logic [7:0]              blank_s;
  logic [3:0]              bcd_next_s;
  logic [NUM_DIGITS-1:0]   sel_next_s;
  logic                    frame_next_s;
  logic [3:0]              bcd_r;
  logic [NUM_DIGITS-1:0]   digit_sel_r;
  logic                    frame_r;
  logic                    err_r;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .tc_o    (tc_s),
    .zero_o  (zero_s)
  );

  // Advance to the next digit only on an enabled terminal count.
  assign step_s       = en_i & tc_s;
  assign shadow_pad_s = 32'(shadow_r);

  // Shadow copy of the digits: changes only on a load strobe, so no tearing.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_r <= {(4 * NUM_DIGITS){1'b0}};
    end else if (load_i) begin
      shadow_r <= digits_i;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Current digit index, wrapping from the last digit back to digit 0.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      index_r <= 3'd0;
    end else if (step_s) begin
      if (index_r == 3'(NUM_DIGITS - 1)) begin
        index_r <= 3'd0;
      end else begin
        index_r <= index_r + 3'd1;
      end
    end else begin
      index_r <= index_r;
    end
  end

  // Per-digit invalid and leading-zero flags, scanned from the top digit down.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    inv_s      = 8'd0;
    lz_s       = 8'd0;
    blank_s    = 8'd0;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      dig_s[k]   = shadow_pad_s[4*k +: 4];
      upper_zero = upper_zero & (dig_s[k] == 4'd0);
      lz_s[k]    = upper_zero;
      inv_s[k]   = ~bcd_valid(dig_s[k]);
      blank_s[k] = inv_s[k] | (blank_lz_i & lz_s[k] & (k != 0));
    end
  end

  // Next output values from the current slot state.
  always_comb begin
    bcd_next_s   = 4'd0;
    sel_next_s   = NUM_DIGITS'(DIGIT_OFF);
    frame_next_s = 1'b0;
    if (inv_s[index_r]) begin
      bcd_next_s = 4'd0;
    end else begin
      bcd_next_s = dig_s[index_r];
    end
    if (!en_i || zero_s || blank_s[index_r]) begin
      sel_next_s = NUM_DIGITS'(DIGIT_OFF);
    end else begin
      sel_next_s = NUM_DIGITS'(sel_onehot_n(index_r));
    end
    if (step_s && (index_r == 3'(NUM_DIGITS - 1))) begin
      frame_next_s = 1'b1;
    end else begin
      frame_next_s = 1'b0;
    end
  end

  // Output registers; the error flag is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bcd_r       <= 4'd0;
      digit_sel_r <= NUM_DIGITS'(DIGIT_OFF);
      frame_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      bcd_r       <= bcd_next_s;
      digit_sel_r <= sel_next_s;
      frame_r     <= frame_next_s;
      err_r       <= err_r | (|inv_s);
    end
  end

  assign bcd_o       = bcd_r;
  assign digit_sel_o = digit_sel_r;
  assign frame_o     = frame_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_digit_scan.sv
// Directed self-checking bench for digit_scan with NUM_DIGITS=4, SCAN_DIV=4.
module tb_digit_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] digits;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  sel;
  logic        frame;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  digit_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .load_i      (load),
    .digits_i    (digits),
    .blank_lz_i  (blank_lz),
    .bcd_o       (bcd),
    .digit_sel_o (sel),
    .frame_o     (frame),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check a full 16-cycle frame starting from slot 0, loading val at its first edge.
  // lit_mask bit k: digit k lights; exp_bcd holds the expected code per slot.
  task automatic run_frame(input string tag, input logic [15:0] val, input logic lz,
                           input logic [3:0] lit_mask, input logic [15:0] exp_bcd);
    logic [3:0] exp_sel;
    int slot;
    int pos;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        load     = 1'b1;
        digits   = val;
        blank_lz = lz;
      end
      cyc();
      load = 1'b0;
      slot = i / 4;
      pos  = i % 4;
      if (pos != 0 && lit_mask[slot]) exp_sel = ~(4'b0001 << slot);
      else                            exp_sel = 4'hF;
      check({tag, " sel"}, 16'(sel), 16'(exp_sel));
      if (pos != 0) check({tag, " bcd"}, 16'(bcd), 16'(exp_bcd[4*slot +: 4]));
      check({tag, " frame"}, 16'(frame), (i == 15) ? 16'd1 : 16'd0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    digits   = 16'h0000;
    blank_lz = 1'b0;
    cyc();
    cyc();
    check("rst sel",   16'(sel),   16'h000F);
    check("rst bcd",   16'(bcd),   16'h0000);
    check("rst frame", 16'(frame), 16'h0000);
    check("rst err",   16'(err),   16'h0000);

    // Normal scanning, two consecutive frames.
    rst_n = 1'b1;
    en    = 1'b1;
    run_frame("f1234a", 16'h1234, 1'b0, 4'b1111, 16'h1234);
    run_frame("f1234b", 16'h1234, 1'b0, 4'b1111, 16'h1234);

    // Leading-zero blanking on and off, and the all-zero value.
    run_frame("lz50on",  16'h0050, 1'b1, 4'b0011, 16'h0050);
    run_frame("lz50off", 16'h0050, 1'b0, 4'b1111, 16'h0050);
    run_frame("zero",    16'h0000, 1'b1, 4'b0001, 16'h0000);
    check("err clean", 16'(err), 16'h0000);

    // Invalid code in digit 1: dark slot, bcd forced to 0, sticky error.
    run_frame("inv", 16'h12A4, 1'b0, 4'b1101, 16'h1204);
    check("err set", 16'(err), 16'h0001);

    // Load on the terminal-count edge of slot 0.
    blank_lz = 1'b0;
    cyc(); check("tc c1 sel", 16'(sel), 16'h000F);
    cyc(); check("tc c2 bcd", 16'(bcd), 16'h0004);
    cyc(); check("tc c3 sel", 16'(sel), 16'h000E);
    load = 1'b1; digits = 16'h9876;
    cyc(); load = 1'b0;
    check("tc c4 bcd", 16'(bcd), 16'h0004);
    check("tc c4 sel", 16'(sel), 16'h000E);
    cyc(); check("tc c5 sel", 16'(sel), 16'h000F);
    check("tc c5 bcd", 16'(bcd), 16'h0007);
    cyc(); check("tc c6 sel", 16'(sel), 16'h000D);
    check("tc c6 bcd", 16'(bcd), 16'h0007);
    check("err sticky", 16'(err), 16'h0001);

    // Enable dropped mid-slot, then resumed from the held position.
    en = 1'b0;
    cyc(); check("en0 c7 sel",   16'(sel),   16'h000F);
    check("en0 c7 frame", 16'(frame), 16'h0000);
    cyc(); check("en0 c8 sel",   16'(sel),   16'h000F);
    en = 1'b1;
    cyc(); check("en1 c9 sel",   16'(sel),   16'h000D);
    check("en1 c9 bcd", 16'(bcd), 16'h0007);
    cyc(); check("en1 c10 sel",  16'(sel),   16'h000D);
    cyc(); check("en1 c11 sel",  16'(sel),   16'h000F);
    check("en1 c11 bcd", 16'(bcd), 16'h0008);
    cyc(); check("en1 c12 sel",  16'(sel),   16'h000B);
    check("en1 c12 bcd", 16'(bcd), 16'h0008);

    // Reset in the middle of the digit 2 slot.
    rst_n = 1'b0;
    cyc();
    check("mrst sel",   16'(sel),   16'h000F);
    check("mrst bcd",   16'(bcd),   16'h0000);
    check("mrst frame", 16'(frame), 16'h0000);
    check("mrst err",   16'(err),   16'h0000);
    rst_n = 1'b1;
    cyc(); check("restart dead sel", 16'(sel), 16'h000F);
    cyc(); check("restart d0 sel",   16'(sel), 16'h000E);
    check("restart d0 bcd", 16'(bcd), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
